// File: rtl/merge_output_buffer.sv
// Output stage of the bitonic merge network: a first-word-fall-through tuple FIFO
// with early stall generation, so that tuples still inside the 5-stage network can land.
module merge_output_buffer #(
    parameter int DATA_WIDTH = 128,
    parameter int KEY_WIDTH  = 80,
    parameter int DEPTH      = 16,
    parameter int SLACK      = 6
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic [16*DATA_WIDTH-1:0]   i_elems,
    input  logic                       i_stall,
    input  logic                       i_switch_output,
    output logic                       o_stall,
    output logic [16*DATA_WIDTH-1:0]   o_data,
    output logic                       o_valid,
    input  logic                       i_ready,
    output logic                       o_last,
    output logic [31:0]                o_run_len,
    output logic                       o_overflow
);

    localparam int N_ELEMS = 16;
    localparam int TUPLE_W = N_ELEMS * DATA_WIDTH;
    localparam int ENTRY_W = TUPLE_W + 1;
    localparam int PTR_W   = $clog2(DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam logic [CNT_W-1:0] STALL_TH = CNT_W'(DEPTH - SLACK);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    // Parameter sanity: these blocks are empty and only elaborate on a bad configuration.
    if (KEY_WIDTH > DATA_WIDTH) begin : g_bad_key_width
    end
    if ((DEPTH < 8) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    end
    if ((SLACK < 6) || (SLACK > DEPTH)) begin : g_bad_slack
    end

    logic [ENTRY_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               stall_q, stall_d;
    logic               overflow_q, overflow_d;
    logic [31:0]        run_cnt_q, run_cnt_d;
    logic [31:0]        run_len_q, run_len_d;

    logic               push;
    logic               pop;
    logic               full;
    logic               push_ok;
    logic               valid;
    logic [ENTRY_W-1:0] head;

    // Handshake: a tuple transfers on every cycle where o_valid and i_ready are both high;
    // o_valid depends only on stored occupancy, never on i_ready.
    assign valid = (count_q != '0);
    assign head  = mem_q[rd_ptr_q];

    always_comb begin
        push    = ~i_stall;
        pop     = valid & i_ready;
        full    = (count_q == FULL_CNT);
        // A full FIFO still accepts a push when a pop frees a slot in the same cycle.
        push_ok = push & (~full | pop);

        wr_ptr_d   = wr_ptr_q + PTR_W'(push_ok);
        rd_ptr_d   = rd_ptr_q + PTR_W'(pop);
        count_d    = count_q + CNT_W'(push_ok) - CNT_W'(pop);
        overflow_d = overflow_q | (push & ~push_ok);
        stall_d    = (count_d >= STALL_TH);
    end

    always_comb begin
        run_cnt_d = run_cnt_q;
        run_len_d = run_len_q;
        if (pop) begin
            if (head[TUPLE_W]) begin
                run_len_d = run_cnt_q + 32'd1;
                run_cnt_d = '0;
            end else begin
                run_cnt_d = run_cnt_q + 32'd1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            stall_q    <= 1'b1;
            overflow_q <= 1'b0;
            run_cnt_q  <= '0;
            run_len_q  <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            stall_q    <= stall_d;
            overflow_q <= overflow_d;
            run_cnt_q  <= run_cnt_d;
            run_len_q  <= run_len_d;
        end
    end

    // Storage carries no reset; only the pointers and count define what is live.
    always_ff @(posedge i_clk) begin
        if (!i_rst && push_ok) begin
            mem_q[wr_ptr_q] <= {i_switch_output, i_elems};
        end
    end

    assign o_stall    = stall_q;
    assign o_valid    = valid;
    assign o_data     = head[TUPLE_W-1:0];
    assign o_last     = valid & head[TUPLE_W];
    assign o_run_len  = run_len_q;
    assign o_overflow = overflow_q;

endmodule

// File: tb/tb_merge_output_buffer.sv
// Bench for merge_output_buffer: random stimulus checked every cycle against a queue model,
// plus literal expectations for reset, single tuple, fill, overflow and run length.
module tb_merge_output_buffer;

    localparam int DW    = 128;
    localparam int DEPTH = 16;
    localparam int SLACK = 6;
    localparam int TW    = 16 * DW;

    logic            clk = 1'b0;
    logic            rst;
    logic [TW-1:0]   i_elems;
    logic            i_stall;
    logic            i_switch_output;
    logic            o_stall;
    logic [TW-1:0]   o_data;
    logic            o_valid;
    logic            i_ready;
    logic            o_last;
    logic [31:0]     o_run_len;
    logic            o_overflow;

    always #5 clk = ~clk;

    merge_output_buffer #(
        .DATA_WIDTH(DW), .KEY_WIDTH(80), .DEPTH(DEPTH), .SLACK(SLACK)
    ) dut (
        .i_clk(clk), .i_rst(rst), .i_elems(i_elems), .i_stall(i_stall),
        .i_switch_output(i_switch_output), .o_stall(o_stall), .o_data(o_data),
        .o_valid(o_valid), .i_ready(i_ready), .o_last(o_last),
        .o_run_len(o_run_len), .o_overflow(o_overflow)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Model: queue of {tag, tuple}, sticky overflow, run counter, expected stall.
    logic [TW:0]  exp_q[$];
    bit           m_ovf;
    logic [31:0]  m_run_cnt;
    logic [31:0]  m_run_len;
    bit           m_stall;
    bit           chk_en = 0;
    logic [5:0]   hist = '1;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic model_step();
        logic [TW:0] item;
        if (rst) begin
            exp_q.delete();
            m_ovf = 0; m_run_cnt = 0; m_run_len = 0; m_stall = 1;
        end else begin
            if (exp_q.size() != 0 && i_ready) begin
                item = exp_q.pop_front();
                m_run_cnt = m_run_cnt + 1;
                if (item[TW]) begin
                    m_run_len = m_run_cnt;
                    m_run_cnt = 0;
                end
            end
            if (!i_stall) begin
                if (exp_q.size() < DEPTH) exp_q.push_back({i_switch_output, i_elems});
                else m_ovf = 1;
            end
            m_stall = (exp_q.size() >= DEPTH - SLACK);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("stall", o_stall, m_stall);
            chk("valid", o_valid, exp_q.size() != 0);
            chk("overflow", o_overflow, m_ovf);
            chk("run_len", o_run_len, m_run_len);
            if (exp_q.size() != 0) begin
                chk("last", o_last, exp_q[0][TW]);
                n_checks++;
                if (o_data !== exp_q[0][TW-1:0]) begin
                    n_errors++;
                    $display("FAIL data: got %h expected %h (low 64 bits)", o_data[63:0], exp_q[0][63:0]);
                end
            end
        end
    end

    function automatic logic [TW-1:0] rand_tuple();
        logic [TW-1:0] t;
        for (int w = 0; w < TW / 32; w++) t[w*32 +: 32] = $urandom;
        return t;
    endfunction

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        hist = {hist[4:0], o_stall};
    endtask

    // Network stand-in: honours o_stall with five cycles of pipeline delay.
    task automatic drive_follow();
        i_stall         = hist[5];
        i_elems         = rand_tuple();
        i_switch_output = ($urandom_range(0, 7) == 0);
    endtask

    task automatic do_reset();
        rst = 1; i_stall = 1; i_ready = 0; i_switch_output = 0;
        tick(); tick();
        rst = 0;
        tick();
    endtask

    task automatic drain(input string name);
        i_stall = 1; i_ready = 1;
        for (int c = 0; c < 64 && exp_q.size() != 0; c++) tick();
        chk(name, o_valid, 0);
    endtask

    task automatic force_fill();
        i_ready = 0;
        for (int i = 0; i < DEPTH; i++) begin
            i_stall = 0; i_elems = rand_tuple(); i_switch_output = 0;
            tick();
        end
        i_stall = 1;
    endtask

    initial begin
        int pushed;
        int seen;
        logic [TW-1:0] dropped;

        rst = 1; i_stall = 1; i_ready = 0; i_elems = '0; i_switch_output = 0;
        tick(); chk_en = 1; tick();
        chk("reset_stall", o_stall, 1);
        chk("reset_valid", o_valid, 0);
        chk("reset_last", o_last, 0);
        chk("reset_run_len", o_run_len, 0);
        chk("reset_overflow", o_overflow, 0);
        rst = 0;
        tick();
        chk("stall_after_reset", o_stall, 0);

        // Single tuple with elements 0..15.
        i_elems = '0;
        for (int k = 0; k < 16; k++) i_elems[k*DW +: DW] = DW'(k);
        i_stall = 0; i_ready = 1;
        tick();
        i_stall = 1;
        chk("single_valid", o_valid, 1);
        for (int k = 0; k < 16; k++) chk("single_elem", o_data[k*DW +: 64], 64'(k));
        tick();
        chk("single_empty", o_valid, 0);

        // Backpressure fill: consumer stalled, network follows o_stall.
        i_ready = 0;
        repeat (30) begin drive_follow(); tick(); end
        chk("bp_stall_high", o_stall, 1);
        chk("bp_fill_level", exp_q.size(), 15);
        chk("bp_no_overflow", o_overflow, 0);
        i_ready = 1;
        repeat (40) begin drive_follow(); tick(); end
        drain("bp_drained");
        chk("bp_stall_low", o_stall, 0);

        // Full FIFO with simultaneous push and pop.
        force_fill();
        chk("full_valid", o_valid, 1);
        chk("full_level", exp_q.size(), 16);
        i_ready = 1;
        repeat (10) begin
            i_stall = 0; i_elems = rand_tuple(); i_switch_output = 0;
            tick();
        end
        chk("full_pp_level", exp_q.size(), 16);
        chk("full_pp_no_overflow", o_overflow, 0);
        drain("full_drained");

        // Run length from a fresh reset.
        do_reset();
        i_ready = 0;
        for (int i = 0; i < 7; i++) begin
            i_stall = 0; i_elems = rand_tuple(); i_switch_output = (i == 6);
            tick();
        end
        i_stall = 1; i_switch_output = 0; i_ready = 1;
        for (int i = 0; i < 7; i++) begin
            chk("run_last_tag", o_last, (i == 6));
            tick();
        end
        chk("run_len_7", o_run_len, 7);
        for (int i = 0; i < 3; i++) begin
            i_stall = 0; i_elems = rand_tuple(); i_switch_output = (i == 2);
            tick();
        end
        drain("run2_drained");
        chk("run_len_3", o_run_len, 3);

        // Overflow: push into a full FIFO while the consumer is stalled.
        force_fill();
        dropped = '1;
        i_stall = 0; i_elems = dropped; i_switch_output = 1;
        tick();
        i_stall = 1; i_switch_output = 0;
        chk("overflow_set", o_overflow, 1);
        i_ready = 1; seen = 0;
        for (int c = 0; c < 64 && o_valid; c++) begin
            seen++;
            chk("dropped_absent", (o_data == dropped), 0);
            tick();
        end
        chk("overflow_drain_count", seen, 16);

        // Pointer wrap: 100 tuples with random consumer readiness.
        pushed = 0;
        for (int c = 0; c < 3000 && pushed < 100; c++) begin
            drive_follow();
            i_ready = ($urandom_range(0, 1) == 1);
            if (!i_stall) pushed++;
            tick();
        end
        chk("wrap_pushed", pushed, 100);
        drain("wrap_drained");
        chk("overflow_sticky", o_overflow, 1);

        do_reset();
        chk("overflow_cleared", o_overflow, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/merge_output_buffer.md
# merge_output_buffer

Output stage directly downstream of the 32-input bitonic merge network in the 16-wide merger tree. It captures the lower 16-element tuple emitted by the network on every non-stalled cycle and holds it in a first-word-fall-through tuple FIFO. It presents the tuple to the next tree level through a valid/ready handshake. It generates the network's input `stall` early enough that no tuple already in flight in the 5-stage network is ever lost.

## Interface
- `DATA_WIDTH`, 128: width of one element.
- `KEY_WIDTH`, 80: key field, bits `[KEY_WIDTH-1:0]` of each element; carried, not inspected.
- `DEPTH`, 16: FIFO depth in tuples; power of two, at least 8.
- `SLACK`, 6: free entries reserved for in-flight tuples; must be at least network depth + 1 (5 + 1).

Ports:
- `i_clk` in 1: the single clock for the block.
- `i_rst` in 1: synchronous, active-high reset.
- `i_elems` in 16*DATA_WIDTH: network `o_elems_0`, the lower sorted half.
- `i_stall` in 1: network `o_stall`. Low means `i_elems` carries a new tuple this cycle.
- `i_switch_output` in 1: network `o_switch_output`. Tags the tuple as last of a run.
- `o_stall` out 1: drives network `stall`. Registered.
- `o_data` out 16*DATA_WIDTH: FIFO head tuple.
- `o_valid` out 1: head tuple valid.
- `i_ready` in 1: consumer accepts the head.
- `o_last` out 1: switch tag stored with the head tuple.
- `o_run_len` out 32: tuple count of the most recently completed run.
- `o_overflow` out 1: sticky error flag, set on a push into a full FIFO.

## Operation
- Storage: `DEPTH` entries, each 16*DATA_WIDTH+1 bits (tuple plus tag). Write and read pointers are log2(DEPTH) bits and wrap modulo `DEPTH`. Occupancy `count` is log2(DEPTH)+1 bits.
- Push: occurs on any cycle with `i_stall`=0. Writes {`i_switch_output`, `i_elems`} at the write pointer and increments the write pointer.
- Pop: occurs on any cycle with `o_valid`=1 and `i_ready`=1. Increments the read pointer.
- `count_next` = `count` + push − pop, with each term 0 or 1.
- Full FIFO, pop in the same cycle: the push is accepted and `count` is unchanged.
- Full FIFO, no pop: the tuple is dropped, `o_overflow` sets and stays set until reset, and pointers and `count` are unchanged.
- Empty FIFO with a push: no bypass. The tuple becomes visible on the next cycle.
- `o_valid` = (`count` != 0). `o_data` and `o_last` always show the entry at the read pointer.
- Stall generation: `o_stall` <= (`count_next` >= DEPTH−SLACK). Evaluated every cycle, independent of `i_stall`.
- Run length: `run_cnt` is a 32-bit counter that increments on each pop.
  - On a pop with `o_last`=1: `o_run_len` <= `run_cnt`+1, then `run_cnt` clears to 0.
  - `run_cnt` wraps at 2^32 with no saturation.
- Reset: pointers, `count`, `run_cnt`, `o_run_len`, and `o_overflow` clear to 0, and `o_stall`=1. Reset overrides any push or pop in the same cycle. Tuples in flight inside the network at reset are discarded.

## Timing
- Reset values: `o_stall`=1, `o_valid`=0, `o_last`=0, `o_run_len`=0, `o_overflow`=0. `o_data` is don't-care while `o_valid`=0.
- First cycle after `i_rst` deasserts: `o_stall` evaluates to 0, provided DEPTH−SLACK > 0.
- Push-to-valid latency: 1 cycle. A push at edge t gives `o_valid`=1 after edge t.
- Throughput: one push and one pop per cycle sustained, with no bubbles.
- Stall-to-response: `o_stall` rising at edge t freezes network stage 1 at edge t+1. Up to SLACK−1 = 5 further pushes can still arrive, and the reserved slack absorbs them, so `o_overflow` never sets in legal operation.
- `o_stall` falls one cycle after `count_next` drops below DEPTH−SLACK.
- `o_valid` does not depend combinationally on `i_ready`. `o_stall` does not depend combinationally on any input.

## Test plan
- Reset then single tuple: hold `i_rst` 2 cycles (expect `o_stall`=1, `o_valid`=0). Push tuple with elements 0..15, `i_ready`=1. Expect `o_valid`=1 exactly one cycle after the push with `o_data` = 0..15, and `count` back to 0 the next cycle.
- Backpressure fill: `i_ready`=0, push every cycle a 5-stage delayed model of `o_stall`. Expect `o_stall` to rise when `count_next` reaches 10, `count` to peak at 16 or less, and `o_overflow`=0. Release `i_ready`: all tuples drain in order, `o_stall` falls once `count` < 10.
- Full with simultaneous push and pop: preload 16, then push and pop together. Expect `count`=16, correct ordering, and `o_overflow`=0.
- Overflow: full, `i_ready`=0, force a push (ignore `o_stall`). Expect `o_overflow`=1, the dropped tuple never appears, and the flag stays set until `i_rst`.
- Run length: push 7 tuples with the 7th tagged `i_switch_output`=1, pop all. Expect `o_last`=1 on the 7th, `o_run_len`=7, and the next run counting from 0.
- Pointer wrap: 100 tuples with random `i_ready` (50%). Expect in-order, lossless delivery across repeated wrap of both pointers.
